// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder / program loader:
// opcodes, FSM state type, error codes and the signed-range helper.
package instr_encoder_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RANGE    = 2'd1;
  localparam logic [1:0] ERR_OPCODE   = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  // True when v is representable as a two's-complement number of 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (bits - 32'd1));
    return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle handshake plus instruction-memory write port of the encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_WIDTH = 32'd8
) ();

  logic                  valid_i;
  logic                  ready_o;
  logic                  last_i;
  logic [6:0]            op_i;
  logic [4:0]            rd_i;
  logic [4:0]            rs1_i;
  logic [4:0]            rs2_i;
  logic [2:0]            funct3_i;
  logic [6:0]            funct7_i;
  logic [31:0]           imm_i;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;

  modport master (
    output valid_i, last_i, op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    input  ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  valid_i, last_i, op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    output ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: builds the instruction word and flags
// immediates that do not fit the opcode's format or opcodes it does not know.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_err,
  output logic        op_err
);

  // Format selection, bit scattering and immediate range check per opcode.
  always_comb begin
    word      = 32'h0000_0000;
    range_err = 1'b0;
    op_err    = 1'b0;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: begin
        if ((op == OP_IMM) && ((funct3 == F3_SLL) || (funct3 == F3_SRX))) begin
          word      = {funct7, imm[4:0], rs1, funct3, rd, op};
          range_err = (imm[31:5] != 27'd0);
        end else begin
          word      = {imm[11:0], rs1, funct3, rd, op};
          range_err = !fits_signed(imm, 32'd12);
        end
      end
      OP_REG: begin
        word = {funct7, rs2, rs1, funct3, rd, op};
      end
      OP_STORE: begin
        word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        range_err = !fits_signed(imm, 32'd12);
      end
      OP_BRANCH: begin
        word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        range_err = !fits_signed(imm, 32'd13) || imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        word      = {imm[31:12], rd, op};
        range_err = (imm[11:0] != 12'd0);
      end
      OP_JAL: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        range_err = !fits_signed(imm, 32'd21) || imm[0];
      end
      default: begin
        op_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts field bundles, encodes them and writes one word per
// cycle to consecutive instruction-memory addresses starting at BASE_ADDR.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32'd8,
  parameter int unsigned BASE_ADDR  = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  instr_encoder_if.slave    bus,
  output logic [ADDR_WIDTH:0] count_o,
  output logic              done_o,
  output logic              error_o,
  output logic [1:0]        err_code_o
);

  localparam logic [ADDR_WIDTH-1:0] BASE_W    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   LAST_SLOT = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0]   ONE_CNT   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_r, state_s;
  logic [ADDR_WIDTH:0]   count_r, count_s;
  logic [1:0]            err_r, err_s;
  logic                  we_r, we_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [31:0]           wdata_r, wdata_s;
  logic [31:0]           word_s;
  logic                  range_err_s;
  logic                  op_err_s;
  logic                  ready_s;
  logic                  xfer_s;

  instr_pack u_pack (
    .op        (bus.op_i),
    .rd        (bus.rd_i),
    .rs1       (bus.rs1_i),
    .rs2       (bus.rs2_i),
    .funct3    (bus.funct3_i),
    .funct7    (bus.funct7_i),
    .imm       (bus.imm_i),
    .word      (word_s),
    .range_err (range_err_s),
    .op_err    (op_err_s)
  );

  assign ready_s = (state_r == ST_LOAD);
  // start_i takes priority, so a bundle presented with it is dropped.
  assign xfer_s  = bus.valid_i && ready_s && !start_i;

  // Next-state, counter and write-port decisions.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    err_s   = err_r;
    we_s    = 1'b0;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    if (start_i) begin
      state_s = ST_LOAD;
      count_s = '0;
      err_s   = ERR_NONE;
    end else if (xfer_s) begin
      if (op_err_s) begin
        state_s = ST_ERROR;
        err_s   = ERR_OPCODE;
      end else if (range_err_s) begin
        state_s = ST_ERROR;
        err_s   = ERR_RANGE;
      end else begin
        we_s    = 1'b1;
        addr_s  = BASE_W + count_r[ADDR_WIDTH-1:0];
        wdata_s = word_s;
        count_s = count_r + ONE_CNT;
        if (bus.last_i) begin
          state_s = ST_DONE;
        end else if (count_r == LAST_SLOT) begin
          state_s = ST_ERROR;
          err_s   = ERR_OVERFLOW;
        end else begin
          state_s = ST_LOAD;
        end
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, counter and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= '0;
      err_r   <= ERR_NONE;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      err_r   <= err_s;
      we_r    <= we_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
    end
  end

  assign bus.ready_o     = ready_s;
  assign bus.mem_we_o    = we_r;
  assign bus.mem_addr_o  = addr_r;
  assign bus.mem_wdata_o = wdata_r;
  assign count_o         = count_r;
  assign done_o          = (state_r == ST_DONE);
  assign error_o         = (state_r == ST_ERROR);
  assign err_code_o      = err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed program-load scenarios plus
// randomized bundles compared against an arithmetic reference of the encoding.
module tb_instr_encoder;

  logic       clk;
  logic       reset;
  logic       start;
  logic       start_s;
  logic [8:0] count;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [2:0] count_s;
  logic       done_s;
  logic       error_s;
  logic [1:0] err_code_s;
  int         checks;
  int         passed;

  instr_encoder_if #(.ADDR_WIDTH(8)) bus ();
  instr_encoder_if #(.ADDR_WIDTH(2)) bus_s ();

  instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start_i(start), .bus(bus),
    .count_o(count), .done_o(done), .error_o(error), .err_code_o(err_code)
  );

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_s (
    .clk(clk), .reset(reset), .start_i(start_s), .bus(bus_s),
    .count_o(count_s), .done_o(done_s), .error_o(error_s), .err_code_o(err_code_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic last, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    bus.valid_i = v; bus.last_i = last; bus.op_i = op; bus.rd_i = rd; bus.rs1_i = rs1;
    bus.rs2_i = rs2; bus.funct3_i = f3; bus.funct7_i = f7; bus.imm_i = imm;
  endtask

  task automatic do_start();
    start = 1'b1; bus.valid_i = 1'b0;
    tick();
    start = 1'b0;
  endtask

  // Reference encoding from the format tables: returns 0 ok, 1 range, 2 opcode.
  function automatic logic [1:0] ref_encode(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, output logic [31:0] w);
    int s;
    logic [31:0] regs;
    logic [31:0] low;
    logic [1:0] code;
    s = $signed(imm);
    regs = (32'(rs1) << 15) | (32'(f3) << 12);
    low = (32'(rd) << 7) | 32'(op);
    code = 2'd0;
    w = 32'd0;
    case (op)
      7'h13, 7'h03, 7'h67: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          if (imm > 32'd31) code = 2'd1;
          w = (32'(f7) << 25) | ((imm % 32'd32) << 20) | regs | low;
        end else begin
          if (s < -2048 || s > 2047) code = 2'd1;
          w = ((imm % 32'd4096) << 20) | regs | low;
        end
      end
      7'h33: w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | low;
      7'h23: begin
        if (s < -2048 || s > 2047) code = 2'd1;
        w = (((imm / 32'd32) % 32'd128) << 25) | (32'(rs2) << 20) | regs
            | ((imm % 32'd32) << 7) | 32'(op);
      end
      7'h63: begin
        if (s < -4096 || s > 4095 || (s % 2) != 0) code = 2'd1;
        w = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) % 32'd64) << 25) | (32'(rs2) << 20)
            | regs | (((imm >> 1) % 32'd16) << 8) | (((imm >> 11) & 32'd1) << 7) | 32'(op);
      end
      7'h37, 7'h17: begin
        if ((imm % 32'd4096) != 32'd0) code = 2'd1;
        w = ((imm / 32'd4096) * 32'd4096) | low;
      end
      7'h6F: begin
        if (s < -1048576 || s > 1048575 || (s % 2) != 0) code = 2'd1;
        w = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) % 32'd1024) << 21)
            | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) % 32'd256) << 12) | low;
      end
      default: code = 2'd2;
    endcase
    return code;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (bus.mem_we_o !== 1'b0) $display("FAIL rst_we: got %b exp 0", bus.mem_we_o); else passed++;
    checks++; if (bus.mem_addr_o !== 8'd0) $display("FAIL rst_addr: got %h exp 0", bus.mem_addr_o); else passed++;
    checks++; if (bus.mem_wdata_o !== 32'd0) $display("FAIL rst_wdata: got %h exp 0", bus.mem_wdata_o); else passed++;
    checks++; if (count !== 9'd0) $display("FAIL rst_count: got %0d exp 0", count); else passed++;
    checks++; if (bus.ready_o !== 1'b0) $display("FAIL rst_ready: got %b exp 0", bus.ready_o); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b exp 0", done); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL rst_error: got %b exp 0", error); else passed++;
    checks++; if (err_code !== 2'd0) $display("FAIL rst_errcode: got %0d exp 0", err_code); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    do_start();
    checks++; if (bus.ready_o !== 1'b1) $display("FAIL start_ready: got %b exp 1", bus.ready_o); else passed++;
    drive(1'b1, 1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    bus.valid_i = 1'b0;
    checks++; if (bus.mem_we_o !== 1'b1) $display("FAIL addi_we: got %b exp 1", bus.mem_we_o); else passed++;
    checks++; if (bus.mem_addr_o !== 8'd0) $display("FAIL addi_addr: got %h exp 0", bus.mem_addr_o); else passed++;
    checks++; if (bus.mem_wdata_o !== 32'h00500093) $display("FAIL addi_wdata: got %h exp 00500093", bus.mem_wdata_o); else passed++;
    checks++; if (count !== 9'd1) $display("FAIL addi_count: got %0d exp 1", count); else passed++;
    tick();
    checks++; if (bus.mem_we_o !== 1'b0) $display("FAIL addi_pulse: got %b exp 0", bus.mem_we_o); else passed++;
  endtask

  task automatic test_back_to_back();
    do_start();
    drive(1'b1, 1'b0, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    drive(1'b1, 1'b0, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    checks++; if (bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 8'd0 || bus.mem_wdata_o !== 32'h0020A423)
      $display("FAIL sw_write: got we %b addr %h data %h exp 1 00 0020a423", bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o); else passed++;
    tick();
    bus.valid_i = 1'b0;
    checks++; if (bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 8'd1 || bus.mem_wdata_o !== 32'hFE000EE3)
      $display("FAIL beq_write: got we %b addr %h data %h exp 1 01 fe000ee3", bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o); else passed++;
    // jal then lui with last
    do_start();
    drive(1'b1, 1'b0, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    tick();
    drive(1'b1, 1'b1, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    checks++; if (bus.mem_wdata_o !== 32'h008000EF) $display("FAIL jal_wdata: got %h exp 008000ef", bus.mem_wdata_o); else passed++;
    tick();
    checks++; if (bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 8'd1 || bus.mem_wdata_o !== 32'h123452B7)
      $display("FAIL lui_write: got we %b addr %h data %h exp 1 01 123452b7", bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o); else passed++;
    checks++; if (done !== 1'b1 || bus.ready_o !== 1'b0) $display("FAIL last_done: got done %b ready %b exp 1 0", done, bus.ready_o); else passed++;
    tick();
    bus.valid_i = 1'b0;
    checks++; if (bus.mem_we_o !== 1'b0 || count !== 9'd2 || done !== 1'b1)
      $display("FAIL done_hold: got we %b count %0d done %b exp 0 2 1", bus.mem_we_o, count, done); else passed++;
  endtask

  task automatic test_errors();
    do_start();
    drive(1'b1, 1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    tick();
    drive(1'b1, 1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    checks++; if (bus.mem_we_o !== 1'b0) $display("FAIL range_we: got %b exp 0", bus.mem_we_o); else passed++;
    checks++; if (error !== 1'b1 || err_code !== 2'd1 || bus.ready_o !== 1'b0)
      $display("FAIL range_err: got error %b code %0d ready %b exp 1 1 0", error, err_code, bus.ready_o); else passed++;
    tick();
    checks++; if (bus.mem_we_o !== 1'b0 || count !== 9'd1) $display("FAIL err_hold: got we %b count %0d exp 0 1", bus.mem_we_o, count); else passed++;
    do_start();
    checks++; if (error !== 1'b0 || err_code !== 2'd0 || count !== 9'd0 || bus.ready_o !== 1'b1)
      $display("FAIL restart: got error %b code %0d count %0d ready %b exp 0 0 0 1", error, err_code, count, bus.ready_o); else passed++;
    drive(1'b1, 1'b0, 7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    bus.valid_i = 1'b0;
    checks++; if (bus.mem_we_o !== 1'b0 || error !== 1'b1 || err_code !== 2'd2)
      $display("FAIL opcode_err: got we %b error %b code %0d exp 0 1 2", bus.mem_we_o, error, err_code); else passed++;
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    logic [1:0] code;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_s.valid_i = 1'b1; bus_s.last_i = 1'b0; bus_s.op_i = 7'h13; bus_s.rd_i = 5'($urandom);
      bus_s.rs1_i = 5'($urandom); bus_s.rs2_i = 5'd0; bus_s.funct3_i = 3'd0; bus_s.funct7_i = 7'd0;
      bus_s.imm_i = 32'($urandom_range(0, 2047));
      code = ref_encode(bus_s.op_i, bus_s.rd_i, bus_s.rs1_i, 5'd0, 3'd0, 7'd0, bus_s.imm_i, w);
      tick();
      if (i < 4) begin
        checks++; if (bus_s.mem_we_o !== 1'b1 || bus_s.mem_addr_o !== 2'(i) || bus_s.mem_wdata_o !== w || code !== 2'd0)
          $display("FAIL ovf_write%0d: got we %b addr %0d data %h exp 1 %0d %h", i, bus_s.mem_we_o, bus_s.mem_addr_o, bus_s.mem_wdata_o, i, w); else passed++;
        checks++; if (count_s !== 3'(i + 1)) $display("FAIL ovf_count%0d: got %0d exp %0d", i, count_s, i + 1); else passed++;
      end else begin
        checks++; if (bus_s.mem_we_o !== 1'b0 || count_s !== 3'd4) $display("FAIL ovf_fifth: got we %b count %0d exp 0 4", bus_s.mem_we_o, count_s); else passed++;
      end
      if (i == 3) begin
        checks++; if (error_s !== 1'b1 || err_code_s !== 2'd3 || bus_s.ready_o !== 1'b0)
          $display("FAIL ovf_flag: got error %b code %0d ready %b exp 1 3 0", error_s, err_code_s, bus_s.ready_o); else passed++;
      end
    end
    bus_s.valid_i = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_start();
    drive(1'b1, 1'b0, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    tick();
    bus.valid_i = 1'b0;
    reset = 1'b1;
    checks++; if (bus.mem_we_o !== 1'b1) $display("FAIL mid_we_before: got %b exp 1", bus.mem_we_o); else passed++;
    tick();
    reset = 1'b0;
    checks++; if (bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 8'd0 || bus.mem_wdata_o !== 32'd0 || count !== 9'd0
                  || bus.ready_o !== 1'b0 || done !== 1'b0 || error !== 1'b0 || err_code !== 2'd0)
      $display("FAIL mid_reset: got we %b addr %h data %h count %0d ready %b exp all zero", bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, count, bus.ready_o); else passed++;
    drive(1'b1, 1'b0, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.valid_i = 1'b0;
    checks++; if (bus.mem_we_o !== 1'b0 || count !== 9'd0 || bus.ready_o !== 1'b1)
      $display("FAIL start_drop: got we %b count %0d ready %b exp 0 0 1", bus.mem_we_o, count, bus.ready_o); else passed++;
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    int m_st;
    int m_cnt;
    logic [1:0] m_ec;
    logic e_we;
    logic [7:0] e_addr;
    logic [31:0] e_data;
    logic [31:0] w;
    logic [1:0] code;
    int v;
    ops = '{7'h13, 7'h03, 7'h67, 7'h33, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0B};
    reset = 1'b1; bus.valid_i = 1'b0;
    tick();
    reset = 1'b0;
    m_st = 0; m_cnt = 0; m_ec = 2'd0; e_addr = 8'd0; e_data = 32'd0;
    for (int n = 0; n < 400; n++) begin
      start = ($urandom_range(0, 99) < ((m_st == 1) ? 2 : 30));
      case ($urandom_range(0, 5))
        0: v = int'($urandom);
        1: v = int'($urandom_range(0, 4095)) - 2048;
        2: v = int'($urandom_range(0, 8191)) - 4096;
        3: v = int'($urandom_range(0, 2097151)) - 1048576;
        4: v = int'($urandom & 32'hFFFF_F000);
        default: v = ($urandom_range(0, 1) == 0) ? 2047 + int'($urandom_range(0, 2)) : -2049 + int'($urandom_range(0, 2));
      endcase
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4, ops[$urandom_range(0, 9)],
            5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 32'(v));
      e_we = 1'b0;
      if (start) begin
        m_st = 1; m_cnt = 0; m_ec = 2'd0;
      end else if (m_st == 1 && bus.valid_i) begin
        code = ref_encode(bus.op_i, bus.rd_i, bus.rs1_i, bus.rs2_i, bus.funct3_i, bus.funct7_i, bus.imm_i, w);
        if (code != 2'd0) begin
          m_st = 3; m_ec = code;
        end else begin
          e_we = 1'b1; e_addr = 8'(m_cnt % 256); e_data = w; m_cnt++;
          if (bus.last_i) m_st = 2;
          else if (m_cnt == 256) begin m_st = 3; m_ec = 2'd3; end
        end
      end
      tick();
      checks++; if (bus.mem_we_o !== e_we) $display("FAIL rnd_we[%0d]: got %b exp %b", n, bus.mem_we_o, e_we); else passed++;
      if (e_we) begin
        checks++; if (bus.mem_addr_o !== e_addr || bus.mem_wdata_o !== e_data)
          $display("FAIL rnd_write[%0d]: got addr %h data %h exp %h %h", n, bus.mem_addr_o, bus.mem_wdata_o, e_addr, e_data); else passed++;
      end
      checks++; if (count !== 9'(m_cnt) || err_code !== m_ec)
        $display("FAIL rnd_count[%0d]: got count %0d code %0d exp %0d %0d", n, count, err_code, m_cnt, m_ec); else passed++;
      checks++; if (bus.ready_o !== (m_st == 1) || done !== (m_st == 2) || error !== (m_st == 3))
        $display("FAIL rnd_state[%0d]: got ready %b done %b error %b exp state %0d", n, bus.ready_o, done, error, m_st); else passed++;
    end
    start = 1'b0; bus.valid_i = 1'b0;
  endtask

  initial begin
    checks = 0; passed = 0;
    start = 1'b0; start_s = 1'b0; reset = 1'b0;
    drive(1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus_s.valid_i = 1'b0; bus_s.last_i = 1'b0; bus_s.op_i = 7'd0; bus_s.rd_i = 5'd0; bus_s.rs1_i = 5'd0;
    bus_s.rs2_i = 5'd0; bus_s.funct3_i = 3'd0; bus_s.funct7_i = 7'd0; bus_s.imm_i = 32'd0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_errors();
    test_overflow();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
